eth_frame_gen: RTL and testbench



---
 rtl/eth_frame_gen_pkg.sv | 26 ++
 rtl/eth_frame_gen_lfsr.sv | 24 ++
 rtl/eth_frame_gen.sv | 176 +++++++++++++++++
 tb/tb_eth_frame_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet frame generator.
// Byte offsets describe the fixed header that precedes the LFSR payload.
package eth_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [15:0] OFF_DST     = 16'd0;
    localparam logic [15:0] OFF_SRC     = 16'd6;
    localparam logic [15:0] OFF_TYPE    = 16'd12;
    localparam logic [15:0] OFF_TS      = 16'd14;
    localparam logic [15:0] OFF_SEQ     = 16'd22;
    localparam logic [15:0] OFF_PAYLOAD = 16'd26;

    // Galois form of x^32+x^22+x^2+x+1, shifting towards bit 0
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/eth_frame_gen_lfsr.sv
// 32-bit Galois LFSR for frame payload; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module eth_frame_gen_lfsr
    import eth_frame_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 32'd1;
        end else if (load) begin
            value <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Byte-wide AXI4-Stream Ethernet frame generator: header, timestamp, sequence
// number and LFSR payload, with programmable length, inter-frame gap and count.
module eth_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter int unsigned C_MIN_LENGTH = 60,
    parameter int unsigned C_MAX_LENGTH = 1514
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [63:0] current_time,
    input  logic        time_running,
    input  logic [15:0] cfg_frame_length,
    input  logic [31:0] cfg_gap,
    input  logic [31:0] cfg_frame_count,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_ethertype,
    input  logic [31:0] cfg_seed,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [63:0] frames_sent,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] MIN_LEN = 16'(C_MIN_LENGTH);
    localparam logic [15:0] MAX_LEN = 16'(C_MAX_LENGTH);

    state_t      state;
    logic        tvalid_r;
    logic        done_r;
    logic [63:0] frames_cnt;
    logic [15:0] idx;
    logic [31:0] gap_cnt;
    logic [31:0] seq;
    logic [31:0] run_cnt;

    logic [15:0] len_lat;
    logic [31:0] gap_lat;
    logic [47:0] dst_lat;
    logic [47:0] src_lat;
    logic [15:0] type_lat;
    logic [63:0] ts_lat;

    logic [31:0]  lfsr_value;
    logic         unused_lfsr_hi;
    logic         hs;
    logic         last_byte;
    logic         run_start;
    logic         start_frame;
    logic [207:0] hdr_vec;
    logic [207:0] hdr_shift;

    function automatic logic [15:0] clamp_len(input logic [15:0] l);
        if (l < MIN_LEN) return MIN_LEN;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    assign hs          = tvalid_r & m_axis_tready;
    assign last_byte   = (idx == len_lat - 16'd1);
    assign run_start   = (state == ST_IDLE) && enable && time_running;
    assign start_frame = run_start ||
                         ((state == ST_GAP) && (gap_cnt == 32'd0) && enable && time_running);

    eth_frame_gen_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (run_start),
        .seed  (cfg_seed),
        .step  (hs && (idx >= OFF_PAYLOAD)),
        .value (lfsr_value)
    );

    assign unused_lfsr_hi = ^lfsr_value[31:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tvalid_r   <= 1'b0;
            done_r     <= 1'b0;
            frames_cnt <= 64'd0;
            idx        <= 16'd0;
            gap_cnt    <= 32'd0;
            seq        <= 32'd0;
            run_cnt    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_start) begin
                        state    <= ST_FRAME;
                        tvalid_r <= 1'b1;
                        idx      <= 16'd0;
                        seq      <= 32'd0;
                        run_cnt  <= 32'd0;
                    end
                end
                ST_FRAME: begin
                    if (hs) begin
                        if (last_byte) begin
                            frames_cnt <= frames_cnt + 64'd1;
                            seq        <= seq + 32'd1;
                            run_cnt    <= run_cnt + 32'd1;
                            tvalid_r   <= 1'b0;
                            idx        <= 16'd0;
                            gap_cnt    <= gap_lat;
                            if ((cfg_frame_count != 32'd0) &&
                                (run_cnt + 32'd1 == cfg_frame_count)) begin
                                state  <= ST_DONE;
                                done_r <= 1'b1;
                            end else if (!enable) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    // Expired gap holds here while enabled but the timer is stopped
                    if (gap_cnt != 32'd0) begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end else if (time_running) begin
                        state    <= ST_FRAME;
                        tvalid_r <= 1'b1;
                        idx      <= 16'd0;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-frame snapshot of configuration and time; pure data, no reset needed
    always_ff @(posedge clk) begin
        if (start_frame) begin
            len_lat  <= clamp_len(cfg_frame_length);
            gap_lat  <= cfg_gap;
            dst_lat  <= cfg_dst_mac;
            src_lat  <= cfg_src_mac;
            type_lat <= cfg_ethertype;
            ts_lat   <= current_time;
        end
    end

    assign hdr_vec   = {dst_lat, src_lat, type_lat, ts_lat, seq};
    assign hdr_shift = hdr_vec << {idx[4:0], 3'b000};

    always_comb begin
        m_axis_tdata = 8'h00;
        if (tvalid_r) begin
            m_axis_tdata = (idx < OFF_PAYLOAD) ? hdr_shift[207:200] : lfsr_value[7:0];
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tvalid_r & last_byte;
    assign frames_sent   = frames_cnt;
    assign busy          = (state != ST_IDLE);
    assign done          = done_r;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: directed runs push expected beats,
// a negedge monitor pops and compares every accepted byte.
module tb_eth_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [63:0] current_time;
    logic        time_running;
    logic [15:0] cfg_frame_length;
    logic [31:0] cfg_gap;
    logic [31:0] cfg_frame_count;
    logic [47:0] cfg_dst_mac;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_ethertype;
    logic [31:0] cfg_seed;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [63:0] frames_sent;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0]  exp_q[$];
    logic [31:0] mdl_lfsr;
    int          rdy_mode = 0;
    int          n_beats = 0;
    int          n_last = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    bit          gap_watch = 1'b0;
    int          exp_low = 0;

    eth_frame_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .current_time     (current_time),
        .time_running     (time_running),
        .cfg_frame_length (cfg_frame_length),
        .cfg_gap          (cfg_gap),
        .cfg_frame_count  (cfg_frame_count),
        .cfg_dst_mac      (cfg_dst_mac),
        .cfg_src_mac      (cfg_src_mac),
        .cfg_ethertype    (cfg_ethertype),
        .cfg_seed         (cfg_seed),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .frames_sent      (frames_sent),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ 32'h80200003;
        return v >> 1;
    endfunction

    task automatic push_frame(input logic [15:0] cfg_len, input logic [63:0] ts, input logic [31:0] seqn);
        int len;
        logic [207:0] hdr;
        logic [7:0] b;
        if (cfg_len < 16'd60) len = 60;
        else if (cfg_len > 16'd1514) len = 1514;
        else len = int'(cfg_len);
        hdr = {cfg_dst_mac, cfg_src_mac, cfg_ethertype, ts, seqn};
        for (int i = 0; i < len; i++) begin
            if (i < 26) begin
                b = hdr[207 - 8*i -: 8];
            end else begin
                b = mdl_lfsr[7:0];
                mdl_lfsr = ref_step(mdl_lfsr);
            end
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    task automatic wait_last(input int target, input int budget);
        int k = 0;
        while (n_last < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_last < target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tlast: saw %0d tlast, required %0d", n_last, target);
        end
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (n_beats < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_beats < target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_beats: saw %0d beats, required %0d", n_beats, target);
        end
    endtask

    task automatic pulse_enable();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
    endtask

    // tready driver; runs #2 after the edge so test writes at #1 take effect first
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(0, 1) == 1);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop, stall stability, bubble and gap-window checks
    initial begin
        logic [8:0] e;
        bit   in_frame = 1'b0;
        bit   stalled = 1'b0;
        bit   prev_valid = 1'b0;
        bit   gap_armed = 1'b0;
        int   low_cnt = 0;
        logic [7:0] prev_data = 8'h00;
        logic prev_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame = 1'b0;
                stalled = 1'b0;
                prev_valid = 1'b0;
                gap_armed = 1'b0;
                continue;
            end
            if (stalled)
                check("hold_while_stalled", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                      64'({1'b1, prev_last, prev_data}));
            if (in_frame)
                check("no_bubble", 64'(m_axis_tvalid), 64'd1);
            if (!m_axis_tvalid) begin
                low_cnt++;
            end else if (!prev_valid) begin
                if (gap_armed && gap_watch)
                    check("gap_low_cycles", 64'(low_cnt), 64'(exp_low));
                gap_armed = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_beats++;
                if (!in_frame) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %0h with nothing expected",
                             {m_axis_tlast, m_axis_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
                end
                if (m_axis_tlast) begin
                    n_last++;
                    last_cyc = cyc;
                    in_frame = 1'b0;
                    low_cnt = 0;
                    gap_armed = gap_watch;
                end else begin
                    in_frame = 1'b1;
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            prev_valid = m_axis_tvalid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        time_running = 1'b1;
        current_time = 64'h0123_4567_89AB_CDEF;
        cfg_frame_length = 16'd64;
        cfg_gap = 32'd0;
        cfg_frame_count = 32'd1;
        cfg_dst_mac = 48'h0A1B_2C3D_4E5F;
        cfg_src_mac = 48'h6655_4433_2211;
        cfg_ethertype = 16'h88B5;
        cfg_seed = 32'h1234_5678;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_frames_sent", frames_sent, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single 64-byte frame, config and time changed after start
        mdl_lfsr = 32'h1234_5678;
        push_frame(16'd64, 64'h0123_4567_89AB_CDEF, 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #1 enable = 1'b0;
        check("first_tvalid_latency", 64'(m_axis_tvalid), 64'd1);
        cfg_dst_mac = 48'h0;
        cfg_ethertype = 16'h0;
        cfg_frame_length = 16'd100;
        current_time = 64'hFFFF_0000_FFFF_0000;
        wait_last(1, 200);
        @(negedge clk);
        check("done_after_frame", 64'(done), 64'd1);
        check("frames_sent_1", frames_sent, 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        check("span_64", 64'(last_cyc - first_cyc), 64'd63);
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);

        // Length clamping, seed 1
        cfg_dst_mac = 48'hFFFF_FFFF_FFFF;
        cfg_src_mac = 48'h0200_0000_0001;
        cfg_ethertype = 16'h0800;
        current_time = 64'h0000_0001_0000_0002;
        cfg_frame_length = 16'd10;
        cfg_seed = 32'd1;
        mdl_lfsr = 32'd1;
        push_frame(16'd10, current_time, 32'd0);
        pulse_enable();
        wait_last(2, 300);
        @(negedge clk);
        check("frames_sent_2", frames_sent, 64'd2);
        check("span_60", 64'(last_cyc - first_cyc), 64'd59);
        repeat (3) @(posedge clk);
        cfg_frame_length = 16'd2000;
        cfg_seed = 32'hCAFE_F00D;
        mdl_lfsr = 32'hCAFE_F00D;
        push_frame(16'd2000, current_time, 32'd0);
        pulse_enable();
        wait_last(3, 2000);
        @(negedge clk);
        check("frames_sent_3", frames_sent, 64'd3);
        check("span_1514", 64'(last_cyc - first_cyc), 64'd1513);

        // Backpressure, three frames, gap 5
        repeat (3) @(posedge clk);
        cfg_frame_length = 16'd64;
        cfg_gap = 32'd5;
        cfg_frame_count = 32'd3;
        cfg_seed = 32'h0BAD_BEEF;
        current_time = 64'hDEAD_BEEF_0000_1111;
        mdl_lfsr = 32'h0BAD_BEEF;
        push_frame(16'd64, current_time, 32'd0);
        push_frame(16'd64, current_time, 32'd1);
        push_frame(16'd64, current_time, 32'd2);
        gap_watch = 1'b1;
        exp_low = 6;
        rdy_mode = 1;
        @(posedge clk); #1 enable = 1'b1;
        wait_last(6, 3000);
        @(negedge clk);
        check("done_after_3", 64'(done), 64'd1);
        check("frames_sent_6", frames_sent, 64'd6);
        @(posedge clk); #1 enable = 1'b0;
        gap_watch = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);

        // Zero seed behaves as seed 1; start gated by time_running
        cfg_frame_length = 16'd60;
        cfg_gap = 32'd0;
        cfg_frame_count = 32'd1;
        cfg_seed = 32'd0;
        mdl_lfsr = 32'd1;
        push_frame(16'd60, current_time, 32'd0);
        rdy_mode = 1;
        @(posedge clk); #1 enable = 1'b1; time_running = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("gated_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("gated_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 time_running = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        wait_last(7, 1000);
        @(negedge clk);
        check("frames_sent_7", frames_sent, 64'd7);
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        // Unlimited run stopped by enable during the second frame
        cfg_frame_count = 32'd0;
        cfg_gap = 32'd2;
        cfg_seed = 32'd5;
        mdl_lfsr = 32'd5;
        push_frame(16'd60, current_time, 32'd0);
        push_frame(16'd60, current_time, 32'd1);
        gap_watch = 1'b1;
        exp_low = 3;
        @(posedge clk); #1 enable = 1'b1;
        wait_last(8, 500);
        repeat (15) @(posedge clk);
        #1 enable = 1'b0;
        wait_last(9, 500);
        @(negedge clk);
        check("busy_after_stop", 64'(busy), 64'd0);
        check("done_after_stop", 64'(done), 64'd0);
        check("frames_sent_9", frames_sent, 64'd9);
        gap_watch = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stopped_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("stopped_queue", 64'(exp_q.size()), 64'd0);

        // Reset while byte 30 is on the bus
        cfg_frame_length = 16'd64;
        cfg_frame_count = 32'd1;
        cfg_gap = 32'd0;
        cfg_seed = 32'd9;
        mdl_lfsr = 32'd9;
        push_frame(16'd64, current_time, 32'd0);
        pulse_enable();
        wait_beats(n_beats + 30, 200);
        #1 rst_n = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rstmid_tlast", 64'(m_axis_tlast), 64'd0);
        check("rstmid_frames_sent", frames_sent, 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_remaining", 64'(exp_q.size()), 64'd34);
        exp_q.delete();
        check("rstmid_tlast_count", 64'(n_last), 64'd9);
        @(posedge clk); #1 rst_n = 1'b1;
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", 64'(m_axis_tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
